// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IFETCH  = 2'd1,
    DACCESS = 2'd2
  } state_t;

  localparam logic [3:0]  MASK_ALL        = 4'b1111;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle watchdog for mem_arbiter; expired is high during the TIMEOUT-th
// consecutive busy cycle after a grant. Built only with MEM_ARB_TIMEOUT_EN.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic busy,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (busy) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = busy && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates core instruction fetches and data accesses onto one memory port,
// data first. Optional busy watchdog and sticky err under MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irequest,
  input  logic [31:0] pc_address_out,
  input  logic        request,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] alu_out,
  input  logic [31:0] byte_accessS,
  input  logic [3:0]  masking_byte,
  output logic [31:0] instr_out,
  output logic        ivalid,
  output logic [31:0] dataMem_out,
  output logic        valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic        err
`endif
);

  state_t state, state_nxt;
  logic   grant_d, grant_i;
  logic   expired;
  logic   finish, to_hit;
  logic   dload;

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    unique case (state)
      IDLE: begin
        if (request) begin
          grant_d   = 1'b1;
          state_nxt = DACCESS;
        end else if (irequest) begin
          grant_i   = 1'b1;
          state_nxt = IFETCH;
        end
      end
      IFETCH, DACCESS: begin
        if (mem_ack || expired) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign mem_req = (state != IDLE);
  assign finish  = mem_req && (mem_ack || expired);
  assign to_hit  = expired && !mem_ack;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_d || grant_i),
    .busy    (mem_req),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst)         err <= 1'b0;
    else if (to_hit) err <= 1'b1;
  end
`else
  assign expired = 1'b0;
`endif

  // Access attributes are frozen at grant; requester inputs may move freely
  // while the transaction is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_mask    <= '0;
      dload       <= 1'b0;
      instr_out   <= '0;
      dataMem_out <= '0;
      ivalid      <= 1'b0;
      valid       <= 1'b0;
    end else begin
      ivalid <= 1'b0;
      valid  <= 1'b0;

      if (grant_d) begin
        mem_addr  <= alu_out;
        mem_wdata <= byte_accessS;
        mem_we    <= store;
        mem_mask  <= store ? masking_byte : MASK_ALL;
        dload     <= load && !store;
      end else if (grant_i) begin
        mem_addr <= pc_address_out;
        mem_we   <= 1'b0;
        mem_mask <= MASK_ALL;
        dload    <= 1'b0;
      end

      if (finish && state == IFETCH) begin
        ivalid    <= 1'b1;
        instr_out <= to_hit ? '0 : mem_rdata;
      end

      if (finish && state == DACCESS) begin
        valid <= 1'b1;
        if (to_hit)     dataMem_out <= '0;
        else if (dload) dataMem_out <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions scored against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        irequest;
  logic [31:0] pc_address_out;
  logic        request, load, store;
  logic [31:0] alu_out, byte_accessS;
  logic [3:0]  masking_byte;
  logic [31:0] instr_out, dataMem_out;
  logic        ivalid, valid;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  // Model: last delivered instruction / load data
  logic [31:0] exp_instr, exp_dmem;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .irequest       (irequest),
    .pc_address_out (pc_address_out),
    .request        (request),
    .load           (load),
    .store          (store),
    .alu_out        (alu_out),
    .byte_accessS   (byte_accessS),
    .masking_byte   (masking_byte),
    .instr_out      (instr_out),
    .ivalid         (ivalid),
    .dataMem_out    (dataMem_out),
    .valid          (valid),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_mask       (mem_mask),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .err            (err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic ld, input logic st);
    load    = ld;
    store   = st;
    request = ld | st;
  endtask

  task automatic drop(input logic is_data);
    if (is_data) set_data(1'b0, 1'b0);
    else         irequest = 1'b0;
  endtask

  // One complete transaction from an IDLE arbiter with the current levels.
  // Enters and leaves on a negedge; the granted requester drops on its pulse.
  task automatic serve(input int d, input logic [31:0] rdata, input bit drop_mid);
    logic        is_data, is_store, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_mask;
    is_data  = request;
    is_store = store;
    e_we     = is_data && is_store;
    e_addr   = is_data ? alu_out : pc_address_out;
    e_mask   = e_we ? masking_byte : 4'hF;
    e_wdata  = byte_accessS;

    @(negedge clk);
    check("grant_req", mem_req, 1);
    check("grant_addr", mem_addr, e_addr);
    check("grant_we", mem_we, e_we);
    check("grant_mask", mem_mask, e_mask);
    if (e_we) check("grant_wdata", mem_wdata, e_wdata);
    check("stale_pulse", {valid, ivalid}, 0);

    pc_address_out = $urandom;
    alu_out        = $urandom;
    byte_accessS   = $urandom;
    masking_byte   = 4'($urandom);
    if (drop_mid) drop(is_data);

    repeat (d) begin
      @(negedge clk);
      check("busy_req", mem_req, 1);
      check("busy_addr", mem_addr, e_addr);
      check("busy_pulse", {valid, ivalid}, 0);
    end

    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (!is_data)      exp_instr = rdata;
    else if (!e_we)    exp_dmem  = rdata;
    check("done_valid", valid, is_data);
    check("done_ivalid", ivalid, !is_data);
    check("done_instr", instr_out, exp_instr);
    check("done_dmem", dataMem_out, exp_dmem);
    check("done_req", mem_req, 0);
    drop(is_data);
  endtask

  initial begin
    logic [1:0] lv;
    int         dk;

    rst = 1'b1;
    irequest = 0; pc_address_out = 0; set_data(0, 0);
    alu_out = 0; byte_accessS = 0; masking_byte = 0;
    mem_rdata = 0; mem_ack = 0;
    exp_instr = 0; exp_dmem = 0;

    repeat (2) @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_mask", mem_mask, 0);
    check("rst_instr", instr_out, 0);
    check("rst_dmem", dataMem_out, 0);
    check("rst_pulses", {valid, ivalid}, 0);
`ifdef MEM_ARB_TIMEOUT_EN
    check("rst_err", err, 0);
`endif
    rst = 1'b0;

    // Fetch at 0x10, ack two cycles after mem_req rises
    pc_address_out = 32'h0000_0010;
    irequest = 1'b1;
    serve(2, 32'h0000_0093, 1'b0);

    // Simultaneous fetch and load: data wins, fetch follows right after
    alu_out = 32'h0000_0100;
    irequest = 1'b1;
    set_data(1, 0);
    serve(1, 32'hCAFE_0001, 1'b0);
    serve(0, 32'h0000_1111, 1'b0);

    // Store with partial mask leaves dataMem_out untouched
    alu_out = 32'h0000_0104;
    byte_accessS = 32'hDEAD_BEEF;
    masking_byte = 4'b0011;
    set_data(0, 1);
    serve(1, 32'h55AA_55AA, 1'b0);

    // load and store together behave as a store
    alu_out = 32'h0000_0200;
    byte_accessS = 32'h1234_5678;
    masking_byte = 4'b1100;
    set_data(1, 1);
    serve(2, 32'h0BAD_0BAD, 1'b0);

    // Request dropped mid-transaction still completes
    pc_address_out = 32'h0000_0040;
    irequest = 1'b1;
    serve(3, 32'h0000_0013, 1'b1);

    // Ack while IDLE is ignored
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack_pulses", {valid, ivalid}, 0);
    check("idle_ack_instr", instr_out, exp_instr);
    check("idle_ack_dmem", dataMem_out, exp_dmem);
    @(negedge clk);
    check("idle_ack_req", mem_req, 0);

    // Reset during DACCESS, then a late ack
    alu_out = 32'h0000_0300;
    set_data(1, 0);
    @(negedge clk);
    check("rstmid_req", mem_req, 1);
    rst = 1'b1;
    set_data(0, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_instr = 0;
    exp_dmem  = 0;
    check("rstmid_addr", mem_addr, 0);
    check("rstmid_instr", instr_out, 0);
    mem_ack = 1'b1;
    mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ack = 1'b0;
    check("rstmid_valid", valid, 0);
    check("rstmid_req", mem_req, 0);
    @(negedge clk);
    check("rstmid_valid2", valid, 0);
    check("rstmid_dmem", dataMem_out, 0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      lv = 2'($urandom_range(1, 3));
      dk = $urandom_range(0, 2);
      pc_address_out = $urandom;
      alu_out        = $urandom;
      byte_accessS   = $urandom;
      masking_byte   = 4'($urandom);
      irequest = lv[1];
      if (lv[0]) set_data(dk != 1, dk != 0);
      for (int s = 0; s < 2 && (request || irequest); s++)
        serve($urandom_range(0, 4), $urandom, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("gap_req", mem_req, 0);
      end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Load never acked: abort after 8 busy cycles
    alu_out = 32'h0000_0400;
    set_data(1, 0);
    repeat (8) begin
      @(negedge clk);
      check("to_busy_req", mem_req, 1);
      check("to_busy_err", err, 0);
    end
    @(negedge clk);
    exp_dmem = 0;
    check("to_valid", valid, 1);
    check("to_dmem", dataMem_out, 0);
    check("to_err", err, 1);
    check("to_req", mem_req, 0);
    set_data(0, 0);
    pc_address_out = 32'h0000_0500;
    irequest = 1'b1;
    serve(2, 32'h0000_00B3, 1'b0);
    check("to_err_sticky", err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_instr = 0;
    check("to_err_cleared", err, 0);
`else
    // Without the watchdog a busy state waits past 255 cycles
    alu_out = 32'h0000_0400;
    set_data(1, 0);
    serve(300, 32'h0000_ABCD, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the number of busy cycles without mem_ack before an abort; it is used only when MEM_ARB_TIMEOUT_EN is defined.
REQ-002 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 irequest  in  1  core instruction-fetch request (level).
REQ-005 pc_address_out  in  32  fetch address.
REQ-006 request  in  1  core data request (level), equal to load|store.
REQ-007 load  in  1  data read.
REQ-008 store  in  1  data write.
REQ-009 alu_out  in  32  data address.
REQ-010 byte_accessS  in  32  store data.
REQ-011 masking_byte  in  4  store byte enables.
REQ-012 instr_out  out  32  fetched instruction, registered.
REQ-013 ivalid  out  1  one-cycle pulse marking instr_out valid.
REQ-014 dataMem_out  out  32  load data, registered.
REQ-015 valid  out  1  one-cycle pulse marking data access complete.
REQ-016 mem_req  out  1  unified memory request.
REQ-017 mem_we  out  1  write enable.
REQ-018 mem_addr  out  32  memory address.
REQ-019 mem_wdata  out  32  write data.
REQ-020 mem_mask  out  4  byte enables.
REQ-021 mem_rdata  in  32  read data.
REQ-022 mem_ack  in  1  one-cycle completion from memory.
REQ-023 err  out  1  sticky timeout flag, present only under MEM_ARB_TIMEOUT_EN.

Function
REQ-024 FSM states SHALL be IDLE, IFETCH and DACCESS.
REQ-025 IDLE: request=1 SHALL go to DACCESS; otherwise irequest=1 SHALL go to IFETCH, so data has fixed priority over fetch.
REQ-026 On grant, address, wdata, mask and we SHALL be captured into registers; mem_req SHALL be 1 on every cycle spent in IFETCH or DACCESS and 0 in IDLE.
REQ-027 IFETCH SHALL drive mem_we=0 and mem_mask=4'b1111.
REQ-028 DACCESS load SHALL drive mem_we=0 and mem_mask=4'b1111; DACCESS store SHALL drive mem_we=1 and mem_mask=masking_byte.
REQ-029 If load and store are both 1, the access SHALL be treated as a store.
REQ-030 mem_ack in IFETCH SHALL register mem_rdata into instr_out, pulse ivalid on the next cycle, and return to IDLE.
REQ-031 mem_ack in DACCESS SHALL pulse valid on the next cycle, register mem_rdata into dataMem_out for loads only (stores leave dataMem_out unchanged), and return to IDLE.
REQ-032 Latency: a request sampled in cycle N gives mem_req in N+1; mem_ack in cycle M gives valid/ivalid in M+1; the next grant is no earlier than M+1.
REQ-033 mem_ack received in IDLE SHALL be ignored.
REQ-034 Requests arriving in a busy state SHALL NOT be latched; requesters hold their level.
REQ-035 Deasserting a request mid-transaction SHALL NOT cancel it; the completion pulse still occurs.

Reset
REQ-036 rst SHALL force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_mask=0, instr_out=0, dataMem_out=0, ivalid=0, valid=0, err=0 and timeout count=0.
REQ-037 Reset mid-transaction SHALL abandon the access; a late mem_ack SHALL be ignored per REQ-033.

Configuration
REQ-038 With MEM_ARB_TIMEOUT_EN defined, a counter SHALL count busy cycles and clear on each grant.
REQ-039 When the counter reaches TIMEOUT with no mem_ack, the block SHALL return to IDLE, set err until reset, and pulse the pending ivalid or valid with data 0.
REQ-040 Without MEM_ARB_TIMEOUT_EN, there SHALL be no counter and no err port, and a busy state SHALL wait indefinitely.

Structure
REQ-041 Package mem_arb_pkg SHALL hold the state enum, the MASK_ALL=4'b1111 constant and the TIMEOUT default.
REQ-042 The timeout counter SHALL be sub-module mem_arb_timer, instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-043 irequest=1 at pc 0x0000_0010; mem_ack two cycles after mem_req with rdata 0x0000_0093 -> ivalid one cycle, instr_out=0x0000_0093, mem_we=0, mem_mask=4'hF.
REQ-044 irequest=1 and load=1 at address 0x100 in the same cycle -> DACCESS granted first, valid pulses; then IFETCH is granted and ivalid follows.
REQ-045 store to 0x104 with data 0xDEADBEEF and mask 4'b0011 -> mem_we=1, mem_mask=4'b0011, mem_wdata=0xDEADBEEF; dataMem_out unchanged after valid.
REQ-046 rst asserted during DACCESS, then mem_ack one cycle later -> IDLE, no valid pulse, mem_req=0.
REQ-047 MEM_ARB_TIMEOUT_EN with TIMEOUT=8 and mem_ack never asserted -> after 8 busy cycles: IDLE, err=1 (sticky), valid pulse with dataMem_out=0.
